// File: rtl/mem_fetch_sequencer.sv
// mem_fetch_sequencer: fetch/decode/execute core of the 8-bit microprocessor.
// Reads a combinational 16x8 memory, runs LDA/ADD/SUB/OUT/HLT against an
// accumulator and hands OUT results to a consumer over valid/ready.

// Accumulator adder shared by ADD and SUB; SUB is acc + ~b + 1 so carry=1
// means "no borrow".
module mem_fetch_alu #(
  parameter int DATA_W = 8
) (
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              co,
  output logic              z
);
  logic [DATA_W-1:0] bx;
  logic [DATA_W:0]   sum;

  // Single adder; invert operand and inject carry-in for subtraction
  always_comb begin
    bx  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, sub};
    y   = sum[DATA_W-1:0];
    co  = sum[DATA_W];
    z   = (sum[DATA_W-1:0] == '0);
  end
endmodule

module mem_fetch_sequencer #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted
);

  // The opcode nibble is fixed at 4 bits, so the word must be operand + 4.
  if (DATA_W != ADDR_W + 4) begin : g_bad_width
    $error("mem_fetch_sequencer: DATA_W must equal ADDR_W+4");
  end

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] operand;
  } instr_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state;
  instr_t            ir;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_z;

  // Memory is addressed by pc only while fetching; otherwise by the operand
  // of the held instruction (this also covers OUT_WAIT and HALT).
  always_comb begin
    mem_addr = (state == S_FETCH) ? pc : ir.operand;
  end

  mem_fetch_alu #(.DATA_W(DATA_W)) u_alu (
    .sub (ir.op == OP_SUB),
    .a   (acc),
    .b   (mem_data),
    .y   (alu_y),
    .co  (alu_c),
    .z   (alu_z)
  );

  // Sequencer FSM and all architectural registers; run=0 freezes everything
  // except reset, which wins unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      ir         <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      halted     <= 1'b0;
    end else if (run) begin
      case (state)
        S_FETCH: begin
          ir    <= instr_t'(mem_data);
          pc    <= pc + ADDR_W'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (ir.op)
            OP_LDA: begin
              acc       <= mem_data;
              zero_flag <= (mem_data == '0);
            end
            OP_ADD, OP_SUB: begin
              acc        <= alu_y;
              carry_flag <= alu_c;
              zero_flag  <= alu_z;
            end
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
              state     <= S_OUT_WAIT;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_OUT_WAIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// Bench for mem_fetch_sequencer: table of whole-program runs plus hand-written
// sequences for freeze, PC wrap and reset-during-OUT_WAIT. OUT values are
// queued per program and popped when a handshake happens.
module tb_mem_fetch_sequencer;

  logic             clk = 1'b0;
  logic             rst, run, out_ready;
  logic [3:0]       mem_addr, pc;
  logic [7:0]       mem_data, out_data, acc;
  logic             out_valid, zero_flag, carry_flag, halted;
  logic [15:0][7:0] mem;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  mem_fetch_sequencer #(.ADDR_W(4), .DATA_W(8), .PC_RESET(4'h0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .pc(pc), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .halted(halted)
  );

  typedef struct {
    string            nm;
    logic [15:0][7:0] img;
    int               stall;
    logic [3:0]       stall_pc;
    int               nout;
    logic [7:0]       outs[3];
    int               halt_edge;
    logic [7:0]       acc;
    logic             z;
    logic             c;
    logic [3:0]       pc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: at the negedge, a pending handshake is popped against the
  // scoreboard; inputs may then be changed #1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst && run && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
      else chk("out_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0][7:0] img);
    mem = img; rst = 1'b1; run = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_flags", {28'h0, out_valid, halted, zero_flag, carry_flag}, 32'h0);
    chk("rst_acc_out", {16'h0, acc, out_data}, 32'h0);
    chk("rst_pc_addr", {24'h0, pc, mem_addr}, 32'h0);
    rst = 1'b0;
  endtask

  // Runs from a just-reset state until halted; optional stall on the first
  // OUT and optional run=0 window after edge frz_at.
  task automatic run_to_halt(input vec_t v, input int frz_at, input int frz_len,
                             input logic [31:0] frz_exp);
    int edges = 0;
    int sl = 0;
    bit seen = 0;
    for (int i = 0; i < v.nout; i++) sb.push_back(v.outs[i]);
    run = 1'b1; out_ready = 1'b1;
    while (!halted && edges < 300) begin
      tick(); edges++;
      if (frz_len > 0 && edges == frz_at) begin
        run = 1'b0;
        for (int k = 0; k < frz_len; k++) begin
          tick(); edges++;
          chk({v.nm, "_frozen"},
              {acc, pc, zero_flag, carry_flag, out_valid, halted, mem_addr, out_data},
              frz_exp);
        end
        run = 1'b1;
        tick(); edges++;
        chk({v.nm, "_add_after_freeze"}, {24'h0, acc}, 32'h02);
      end
      if (v.stall > 0 && !seen && out_valid) begin
        seen = 1; sl = v.stall; out_ready = 1'b0;
      end else if (sl > 0) begin
        chk({v.nm, "_stall_hold"}, {19'h0, out_valid, pc, out_data},
            {19'h0, 1'b1, v.stall_pc, v.outs[0]});
        sl--;
        if (sl == 0) out_ready = 1'b1;
      end
    end
    chk({v.nm, "_halted"}, {31'h0, halted}, 32'h1);
    chk({v.nm, "_halt_edge"}, edges, v.halt_edge + frz_len);
    chk({v.nm, "_acc"}, {24'h0, acc}, {24'h0, v.acc});
    chk({v.nm, "_flags"}, {30'h0, zero_flag, carry_flag}, {30'h0, v.z, v.c});
    chk({v.nm, "_pc"}, {28'h0, pc}, {28'h0, v.pc});
    chk({v.nm, "_halt_addr_valid"}, {27'h0, out_valid, mem_addr}, 32'h0);
    chk({v.nm, "_outs_left"}, sb.size(), 0);
    if (v.nout > 0)
      chk({v.nm, "_out_retained"}, {24'h0, out_data}, {24'h0, v.outs[v.nout-1]});
    sb.delete();
  endtask

  initial begin
    vec_t tbl[4];
    vec_t v;
    logic [15:0][7:0] std_img;
    logic [15:0][7:0] nop_img;

    rst = 1'b1; run = 1'b0; out_ready = 1'b1; mem = '0;

    std_img = {8'h0D, 8'h08, 8'h05, 8'h04, 8'h00, 8'h04, 8'h02, 8'h00,
               8'hF0, 8'hE0, 8'h2B, 8'hE0, 8'h1A, 8'hE0, 8'h19, 8'h08};

    tbl[0].nm = "std";     tbl[0].img = std_img; tbl[0].stall = 0; tbl[0].stall_pc = 4'h0;
    tbl[0].nout = 3; tbl[0].outs[0] = 8'h02; tbl[0].outs[1] = 8'h06; tbl[0].outs[2] = 8'h06;
    tbl[0].halt_edge = 19; tbl[0].acc = 8'h06; tbl[0].z = 1'b0; tbl[0].c = 1'b1; tbl[0].pc = 4'h8;

    tbl[1] = tbl[0]; tbl[1].nm = "stall"; tbl[1].stall = 5; tbl[1].stall_pc = 4'h3;
    tbl[1].halt_edge = 24;

    tbl[2].nm = "add_ovf"; tbl[2].img = '0; tbl[2].stall = 0; tbl[2].stall_pc = 4'h0;
    tbl[2].img[0] = 8'h08; tbl[2].img[1] = 8'h19; tbl[2].img[2] = 8'hF0;
    tbl[2].img[8] = 8'hFF; tbl[2].img[9] = 8'h01;
    tbl[2].nout = 0; tbl[2].outs[0] = 8'h0; tbl[2].outs[1] = 8'h0; tbl[2].outs[2] = 8'h0;
    tbl[2].halt_edge = 6; tbl[2].acc = 8'h00; tbl[2].z = 1'b1; tbl[2].c = 1'b1; tbl[2].pc = 4'h3;

    tbl[3] = tbl[2]; tbl[3].nm = "sub_borrow";
    tbl[3].img[1] = 8'h29; tbl[3].img[8] = 8'h05; tbl[3].img[9] = 8'h07;
    tbl[3].acc = 8'hFE; tbl[3].z = 1'b0; tbl[3].c = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_reset(tbl[i].img);
      run_to_halt(tbl[i], 0, 0, 32'h0);
    end

    // Freeze for 4 cycles while ADD sits in EXEC (after edge 3: acc=0,
    // pc=2, zero=1, carry=0, mem_addr=9).
    do_reset(std_img);
    run_to_halt(tbl[0], 3, 4, {8'h00, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 8'h00});

    // PC wrap across NOPs, then LDA 0xF is fetched and executed again.
    nop_img = '0;
    for (int i = 0; i < 16; i++) nop_img[i] = 8'h50;
    nop_img[0] = 8'h0F;
    do_reset(nop_img);
    run = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      tick();
      if (e % 2 == 1) chk("wrap_pc", {28'h0, pc}, ((e + 1) / 2) % 16);
      if (e == 2) chk("wrap_lda", {24'h0, acc}, 32'h50);
      if (e == 33) chk("wrap_refetch_lda", {28'h0, mem_addr}, 32'hF);
    end
    chk("wrap_end", {23'h0, halted, acc}, {23'h0, 1'b0, 8'h50});

    // Reset while parked in OUT_WAIT with out_ready low, then a clean rerun.
    do_reset(std_img);
    for (int i = 0; i < 3; i++) sb.push_back(tbl[0].outs[i]);
    run = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("ow_parked", {19'h0, out_valid, pc, out_data}, {19'h0, 1'b1, 4'h3, 8'h02});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ow_rst", {15'h0, out_valid, pc, acc, out_data}, 32'h0);
    sb.delete();
    run_to_halt(tbl[0], 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_fetch_sequencer.md
Name: mem_fetch_sequencer

Overview:
- Reader-side controller for the 16x8 program/data memory. The memory is combinational-read, with a 4-bit address and 8-bit data.
- Drives the memory address, fetches 8-bit instructions, decodes them as opcode in the upper nibble and operand address in the lower nibble, and executes them against an internal accumulator.
- Presents an output register to the display/consumer through a valid/ready handshake.
- Forms the control and datapath core of the 8-bit FPGA microprocessor.

Parameters:
- ADDR_W, 4, memory address width; also the width of the operand field.
- DATA_W, 8, memory word and accumulator width. DATA_W must equal ADDR_W+4 (the opcode is always 4 bits).
- PC_RESET, 0, program counter value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates occur on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  advance enable; 0 freezes all state.
- mem_addr  out  ADDR_W  address to memory.
- mem_data  in  DATA_W  memory read data, combinational from mem_addr.
- out_data  out  DATA_W  output register (last value emitted by OUT).
- out_valid  out  1  out_data holds a new, unaccepted value.
- out_ready  in  1  consumer accepts out_data.
- acc  out  DATA_W  accumulator (debug/display).
- pc  out  ADDR_W  program counter (debug).
- zero_flag  out  1  result was zero.
- carry_flag  out  1  carry out of the last ADD/SUB.
- halted  out  1  machine is in HALT.

Behaviour:
- Reset (rst=1 at an edge, takes priority over everything):
  - state=FETCH, pc=PC_RESET, ir=0.
  - acc, out_data, zero_flag and carry_flag are all 0; out_valid=0; halted=0.
  - A reset in any state, including OUT_WAIT or HALT, aborts the instruction and drops out_valid on that edge.
- mem_addr is combinational: pc in FETCH, ir[ADDR_W-1:0] in every other state.
- run=0: no register changes, including no handshake completion. mem_addr remains driven.
- States:
  - FETCH:
    - ir <= mem_data; pc <= pc+1, with modulo-2^ADDR_W wrap (15 to 0).
    - Next state: EXEC.
  - EXEC, decoded by ir[DATA_W-1:DATA_W-4]:
    - 0x0 LDA: acc <= mem_data; zero updated; carry unchanged; next FETCH.
    - 0x1 ADD: {c,acc} <= acc + mem_data; zero and carry updated; next FETCH.
    - 0x2 SUB: {c,acc} <= acc + ~mem_data + 1 (c=1 means no borrow); zero and carry updated; next FETCH.
    - 0xE OUT: out_data <= acc; out_valid <= 1; next OUT_WAIT.
    - 0xF HLT: halted <= 1; next HALT.
    - Any other opcode is a NOP: no register changes; next FETCH.
  - OUT_WAIT:
    - Handshake transfer occurs on an edge with out_valid=1 and out_ready=1. On that edge: out_valid <= 0, next FETCH.
    - Otherwise the state holds, and out_data stays stable.
    - out_ready sampled while out_valid=0 has no effect.
  - HALT: absorbing until rst. mem_addr=ir operand field; no memory-driven updates.
- Flag rules:
  - zero = (DATA_W-bit result == 0).
  - Flags only change on LDA/ADD/SUB (LDA: zero only).
- Latency, with run=1:
  - LDA/ADD/SUB/NOP/HLT take 2 cycles.
  - OUT takes 3 cycles when out_ready=1; add one cycle per cycle out_ready is low in OUT_WAIT.
- out_data retains the last emitted value after acceptance.

Test Plan:
1. Standard image (08 19 E0 1A E0 2B E0 F0 | 00 02 04 00 04 05 08 0D), rst for 2 cycles, then run=1, out_ready=1:
   - out_valid pulses 3 times with out_data 0x02, 0x06, 0x06.
   - halted=1 after the 19th edge; acc=0x06, carry=1, zero=0, pc=0x8.
2. Same image, out_ready=0 for 5 cycles after the first out_valid rises:
   - out_valid and out_data=0x02 are held for 5 cycles, and pc stays at 0x3.
   - Acceptance completes on the first edge where out_ready=1.
   - halted is delayed by exactly 5 cycles (24th edge).
3. Arithmetic edge cases:
   - Image 08 19 F0 with [8]=0xFF, [9]=0x01 gives acc=0x00, zero=1, carry=1.
   - Image 08 29 F0 with [8]=0x05, [9]=0x07 gives acc=0xFE, zero=0, carry=0.
4. PC wrap and NOP:
   - Memory all 0x50 (NOP) except [0]=0x0F (LDA 0xF) and [0xF]=0x50.
   - pc sequences 1 to 15, wraps to 0, then re-executes LDA; acc=0x50; halted stays 0.
5. run=0 for 4 cycles mid-ADD (state EXEC): all outputs frozen. The ADD completes on the first edge after run=1, and totals match scenario 1 delayed by 4 cycles.
6. rst asserted for one cycle while in OUT_WAIT with out_ready=0:
   - Next edge: out_valid=0, out_data=0, pc=0, acc=0.
   - The program then reruns and produces scenario 1 results.
